// File: rtl/forwarding_hazard_unit.sv
// Forwarding-select and load-use stall generator for a 5-stage pipeline.
// Shadows the destination info of the EX and MEM instructions to resolve operand sources in ID.
module forwarding_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic                  stall,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_EX  = 2'b10;

  // x0 is hardwired to zero, so a write to it never produces a usable value
  function automatic logic slot_match(
    input logic                  valid,
    input logic                  rw,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] src,
    input logic                  uses
  );
    return valid & rw & (rd != '0) & (rd == src) & uses;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic                  ex_valid, ex_rw, ex_mr;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  mem_valid, mem_rw;
  logic [REG_ADDR_W-1:0] mem_rd;

  logic ex_m1, ex_m2, mem_m1, mem_m2;
  logic advance;
  logic [1:0] sel_a, sel_b;

  assign ex_m1  = slot_match(ex_valid,  ex_rw,  ex_rd,  id_rs1, id_uses_rs1);
  assign ex_m2  = slot_match(ex_valid,  ex_rw,  ex_rd,  id_rs2, id_uses_rs2);
  assign mem_m1 = slot_match(mem_valid, mem_rw, mem_rd, id_rs1, id_uses_rs1);
  assign mem_m2 = slot_match(mem_valid, mem_rw, mem_rd, id_rs2, id_uses_rs2);

  assign stall   = id_valid & ~flush & ex_valid & ex_mr & (ex_m1 | ex_m2);
  assign advance = id_valid & ~flush & ~stall;

  // Youngest producer wins: EX slot takes priority over MEM slot
  assign sel_a = ex_m1 ? FWD_EX : (mem_m1 ? FWD_MEM : FWD_REG);
  assign sel_b = ex_m2 ? FWD_EX : (mem_m2 ? FWD_MEM : FWD_REG);

  // ID -> EX -> MEM shadow pipeline, selects registered with the ID/EX advance
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_rw     <= 1'b0;
      ex_mr     <= 1'b0;
      ex_rd     <= '0;
      mem_valid <= 1'b0;
      mem_rw    <= 1'b0;
      mem_rd    <= '0;
      forward_a <= FWD_REG;
      forward_b <= FWD_REG;
      stall_cnt <= '0;
    end else begin
      mem_valid <= ex_valid;
      mem_rw    <= ex_rw;
      mem_rd    <= ex_rd;
      if (advance) begin
        ex_valid  <= 1'b1;
        ex_rw     <= id_reg_write;
        ex_mr     <= id_mem_read;
        ex_rd     <= id_rd;
        forward_a <= sel_a;
        forward_b <= sel_b;
      end else begin
        ex_valid  <= 1'b0;
        ex_rw     <= 1'b0;
        ex_mr     <= 1'b0;
        forward_a <= FWD_REG;
        forward_b <= FWD_REG;
      end
      if (stall) stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Scoreboard bench for forwarding_hazard_unit: directed instruction streams, expected
// per-cycle outputs queued by the stimulus and checked by an independent monitor.
module tb_forwarding_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read, flush;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic        stall, stall4;
  logic [1:0]  forward_a, forward_b, forward_a4, forward_b4;
  logic [31:0] stall_cnt;
  logic [3:0]  stall_cnt4;

  always #5 clk = ~clk;

  forwarding_hazard_unit #(.REG_ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .stall(stall), .forward_a(forward_a), .forward_b(forward_b), .stall_cnt(stall_cnt)
  );

  forwarding_hazard_unit #(.REG_ADDR_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .stall(stall4), .forward_a(forward_a4), .forward_b(forward_b4), .stall_cnt(stall_cnt4)
  );

  typedef struct {
    string       name;
    logic        s;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, req);
    end
  endtask

  // Monitor: every cycle presents a result; pop and compare mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] c4;
      e  = exp_q.pop_front();
      c4 = (e.cnt > 32'd15) ? 32'd15 : e.cnt;
      check(e.name, "stall",      {31'd0, stall},      {31'd0, e.s});
      check(e.name, "forward_a",  {30'd0, forward_a},  {30'd0, e.fa});
      check(e.name, "forward_b",  {30'd0, forward_b},  {30'd0, e.fb});
      check(e.name, "stall_cnt",  stall_cnt,           e.cnt);
      check(e.name, "stall4",     {31'd0, stall4},     {31'd0, e.s});
      check(e.name, "forward_a4", {30'd0, forward_a4}, {30'd0, e.fa});
      check(e.name, "forward_b4", {30'd0, forward_b4}, {30'd0, e.fb});
      check(e.name, "stall_cnt4", {28'd0, stall_cnt4}, c4);
    end
  end

  task automatic step(input string nm, input logic v, input int rs1, input int rs2,
                      input logic u1, input logic u2, input int rd, input logic rw,
                      input logic mr, input logic fl, input logic r,
                      input logic es, input logic [1:0] efa, input logic [1:0] efb,
                      input int ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    id_valid = v;  id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_rd = 5'(rd);
    id_reg_write = rw; id_mem_read = mr; flush = fl; rst = r;
    e.name = nm; e.s = es; e.fa = efa; e.fb = efb; e.cnt = 32'(ecnt);
    exp_q.push_back(e);
  endtask

  task automatic alu(input string nm, input int rs1, input int rs2, input int rd,
                     input logic es, input logic [1:0] efa, input logic [1:0] efb, input int ecnt);
    step(nm, 1, rs1, rs2, 1, 1, rd, 1, 0, 0, 0, es, efa, efb, ecnt);
  endtask

  task automatic load(input string nm, input int rs1, input int rd,
                      input logic es, input logic [1:0] efa, input logic [1:0] efb, input int ecnt);
    step(nm, 1, rs1, 0, 1, 0, rd, 1, 1, 0, 0, es, efa, efb, ecnt);
  endtask

  task automatic nop(input string nm, input logic [1:0] efa, input logic [1:0] efb, input int ecnt);
    step(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, efa, efb, ecnt);
  endtask

  initial begin
    rst = 1'b1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_rd = 0; id_reg_write = 0; id_mem_read = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;

    nop("reset_state", 2'b00, 2'b00, 0);

    // back-to-back ALU dependency
    alu("t1_add",  1, 2, 5,  0, 2'b00, 2'b00, 0);
    alu("t1_sub",  5, 1, 6,  0, 2'b00, 2'b00, 0);
    nop("t1_subex",          2'b10, 2'b00, 0);

    // one-gap dependency, then youngest producer wins
    alu("t2_add",  1, 2, 5,  0, 2'b00, 2'b00, 0);
    nop("t2_nop",            2'b00, 2'b00, 0);
    alu("t2_or",   1, 5, 7,  0, 2'b00, 2'b00, 0);
    nop("t2_orex",           2'b00, 2'b01, 0);
    alu("t2_addA", 1, 2, 5,  0, 2'b00, 2'b00, 0);
    alu("t2_addB", 3, 4, 5,  0, 2'b00, 2'b00, 0);
    alu("t2_or2",  1, 5, 7,  0, 2'b00, 2'b00, 0);
    nop("t2_or2ex",          2'b00, 2'b10, 0);

    // load-use stall
    load("t3_lw",  1, 8,     0, 2'b00, 2'b00, 0);
    alu("t3_use",  8, 8, 9,  1, 2'b00, 2'b00, 0);
    alu("t3_hold", 8, 8, 9,  0, 2'b00, 2'b00, 1);
    nop("t3_addex",          2'b01, 2'b01, 1);

    // x0 destinations are ignored
    alu("t4_addi0", 0, 0, 0, 0, 2'b00, 2'b00, 1);
    alu("t4_use0",  0, 0, 1, 0, 2'b00, 2'b00, 1);
    load("t4_lw0",  2, 0,    0, 2'b00, 2'b00, 1);
    alu("t4_luse0", 0, 0, 3, 0, 2'b00, 2'b00, 1);
    nop("t4_ex",             2'b00, 2'b00, 1);

    // flush beats stall
    load("t5_lw",  1, 8,     0, 2'b00, 2'b00, 1);
    step("t5_flush", 1, 8, 1, 1, 1, 9, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1);
    nop("t5_after",          2'b00, 2'b00, 1);

    // reset while stalled with forward_a=10
    alu("t6_add",  1, 2, 5,  0, 2'b00, 2'b00, 1);
    load("t6_lw",  5, 8,     0, 2'b00, 2'b00, 1);
    step("t6_rst", 1, 8, 1, 1, 1, 9, 1, 0, 0, 1, 1, 2'b10, 2'b00, 1);
    alu("t6_post", 8, 1, 9,  0, 2'b00, 2'b00, 0);
    nop("t6_postex",         2'b00, 2'b00, 0);

    // repeated load-use stalls drive the 4-bit counter into saturation
    for (int k = 0; k < 17; k++) begin
      load("sat_lw", 1, 8, 0, (k == 0) ? 2'b00 : 2'b01, (k == 0) ? 2'b00 : 2'b01, k);
      alu("sat_stall", 8, 8, 9, 1, 2'b00, 2'b00, k);
      alu("sat_adv",   8, 8, 9, 0, 2'b00, 2'b00, k + 1);
    end
    nop("sat_end", 2'b01, 2'b01, 17);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time=%0t limit=50000", $time);
    $fatal(1, "timeout");
  end

endmodule
